// File: rtl/bip_control_unit.sv
// BIP control unit: owns the program counter, decodes the fetched instruction into
// datapath strobes, and sequences IDLE/RUN/HALT with stall support and a cycle counter.
module bip_control_unit #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   enable,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  pc_address,
  output logic [INSTR_WIDTH-6:0] operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   op_sub,
  output logic                   wr_acc,
  output logic                   wr_ram,
  output logic                   rd_ram,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  localparam logic [4:0] OpHlt  = 5'b00000;
  localparam logic [4:0] OpSto  = 5'b00001;
  localparam logic [4:0] OpLd   = 5'b00010;
  localparam logic [4:0] OpLdi  = 5'b00011;
  localparam logic [4:0] OpAdd  = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpSubi = 5'b00111;

  localparam logic [1:0] SelRam = 2'd0;
  localparam logic [1:0] SelImm = 2'd1;
  localparam logic [1:0] SelAlu = 2'd2;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   halted_q, halted_d;
  logic [4:0]             opcode;
  logic                   exec;

  assign opcode  = instruction[INSTR_WIDTH-1 -: 5];
  assign operand = instruction[INSTR_WIDTH-6:0];
  assign exec    = (state_q == StRun) && enable;

  // Counter saturates instead of wrapping so long runs never report a small count.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (enable) begin
          cnt_d = cnt_inc;
          if (opcode == OpHlt) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + ADDR_WIDTH'(1);
          end
        end
      end
      StHalt: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  // Zero-latency decode; every strobe is gated by exec so stalls and non-RUN states are inert.
  always_comb begin
    sel_a  = SelRam;
    sel_b  = 1'b0;
    op_sub = 1'b0;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    if (exec) begin
      case (opcode)
        OpSto: wr_ram = 1'b1;
        OpLd: begin
          sel_a  = SelRam;
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OpLdi: begin
          sel_a  = SelImm;
          wr_acc = 1'b1;
        end
        OpAdd: begin
          sel_a  = SelAlu;
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OpAddi: begin
          sel_a  = SelAlu;
          sel_b  = 1'b1;
          wr_acc = 1'b1;
        end
        OpSub: begin
          sel_a  = SelAlu;
          op_sub = 1'b1;
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OpSubi: begin
          sel_a  = SelAlu;
          sel_b  = 1'b1;
          op_sub = 1'b1;
          wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_address  = pc_q;
  assign cycle_count = cnt_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: directed scenarios plus randomized programs,
// all compared against a behavioural model of the instruction sequencer.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] instruction;
  logic [10:0] pc_address;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op_sub, wr_acc, wr_ram, rd_ram, halted;
  logic [31:0] cycle_count;

  // Narrow instance for PC wrap and counter saturation.
  logic        rst4_n = 1'b0;
  logic        start4 = 1'b0;
  logic [15:0] instr4 = 16'h4000;
  logic [3:0]  pc4;
  logic [10:0] operand4;
  logic [1:0]  sel_a4;
  logic        sel_b4, op_sub4, wr_acc4, wr_ram4, rd_ram4, halted4;
  logic [4:0]  cnt4;

  logic [15:0] mem [2048];
  assign instruction = mem[pc_address];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: 0 = idle, 1 = running, 2 = halted
  int          m_mode;
  logic [10:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  bip_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .enable      (enable),
    .instruction (instruction),
    .pc_address  (pc_address),
    .operand     (operand),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .op_sub      (op_sub),
    .wr_acc      (wr_acc),
    .wr_ram      (wr_ram),
    .rd_ram      (rd_ram),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  bip_control_unit #(
    .ADDR_WIDTH (4),
    .CNT_WIDTH  (5)
  ) dut4 (
    .clk         (clk),
    .rst_n       (rst4_n),
    .start       (start4),
    .enable      (1'b1),
    .instruction (instr4),
    .pc_address  (pc4),
    .operand     (operand4),
    .sel_a       (sel_a4),
    .sel_b       (sel_b4),
    .op_sub      (op_sub4),
    .wr_acc      (wr_acc4),
    .wr_ram      (wr_ram4),
    .rd_ram      (rd_ram4),
    .halted      (halted4),
    .cycle_count (cnt4)
  );

  // {sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram} for an executed opcode
  function automatic logic [6:0] exp_ctl(input logic [4:0] op);
    case (op)
      5'd1:    return 7'b00_0_0_0_1_0;
      5'd2:    return 7'b00_0_0_1_0_1;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_0_1;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_0_1;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [61:0] obs_vec();
    return {pc_address, cycle_count, halted, sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram,
            operand};
  endfunction

  function automatic logic [61:0] exp_vec();
    logic [6:0] ctl;
    ctl = (m_mode == 1 && enable) ? exp_ctl(mem[m_pc][15:11]) : 7'b0;
    return {m_pc, m_cnt, (m_mode == 2), ctl, mem[m_pc][10:0]};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc   = '0;
    m_cnt  = '0;
  endtask

  task automatic model_edge(input logic en, input logic st);
    case (m_mode)
      0: if (st) m_mode = 1;
      1: begin
        if (en) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          if (mem[m_pc][15:11] == 5'd0) m_mode = 2;
          else m_pc = m_pc + 11'd1;
        end
      end
      default: begin
        if (st) begin
          m_mode = 1;
          m_pc   = '0;
          m_cnt  = '0;
        end
      end
    endcase
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h4000;
  endtask

  // Called at posedge+1; leaves the DUT running from PC 0 at posedge+1.
  task automatic reset_and_start();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    start  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    model_edge(1'b1, 1'b1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [61:0] got, want;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL reset_hold[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    got = obs_vec(); want = exp_vec();
    total_cnt++;
    if (got !== want) $display("FAIL reset_idle got=%h want=%h", got, want);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start();
    logic [61:0] got, want;
    fill_nop();
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL start[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_decode();
    logic [61:0] got, want;
    fill_nop();
    for (int i = 0; i < 7; i++) mem[i] = {5'(i + 1), 11'h02A};
    mem[7] = {5'b01000, 11'h02A};
    reset_and_start();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL decode[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    logic [61:0] got, want;
    fill_nop();
    mem[5] = {5'b00100, 11'h011};
    reset_and_start();
    for (int i = 0; i < 11; i++) begin
      enable = !(i >= 5 && i < 9);
      start  = (i == 6);
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL stall[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    start  = 1'b0;
  endtask

  task automatic test_halt_restart();
    logic [61:0] got, want;
    fill_nop();
    mem[7] = {5'b00000, 11'h055};
    reset_and_start();
    for (int i = 0; i < 22; i++) begin
      enable = (i < 8) ? 1'b1 : 1'($urandom_range(1));
      start  = (i == 19);
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL halt[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    start  = 1'b0;
  endtask

  task automatic test_wrap();
    int         w_pc, w_cnt;
    logic [9:0] got, want;
    rst4_n = 1'b1;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    w_pc   = 0;
    w_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      got  = {pc4, cnt4, halted4};
      want = {4'(w_pc), 5'(w_cnt), 1'b0};
      total_cnt++;
      if (got !== want || {sel_a4, sel_b4, op_sub4, wr_acc4, wr_ram4, rd_ram4} !== 7'b0)
        $display("FAIL wrap[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      w_pc  = (w_pc + 1) % 16;
      w_cnt = (w_cnt < 31) ? w_cnt + 1 : 31;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    logic [61:0] got, want;
    fill_nop();
    mem[9] = {5'b00011, 11'h123};
    reset_and_start();
    for (int i = 0; i < 9; i++) begin
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    got = obs_vec(); want = exp_vec();
    total_cnt++;
    if (got !== want) $display("FAIL async_pre got=%h want=%h", got, want);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = obs_vec(); want = exp_vec();
    total_cnt++;
    if (got !== want) $display("FAIL async_reset got=%h want=%h", got, want);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL async_idle[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [61:0] got, want;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:11] == 5'd0 && $urandom_range(3) != 0) mem[i][15:11] = 5'b01000;
    end
    reset_and_start();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(3) != 0);
      start  = ($urandom_range(15) == 0);
      @(negedge clk);
      got = obs_vec(); want = exp_vec();
      total_cnt++;
      if (got !== want) $display("FAIL random[%0d] got=%h want=%h", i, got, want);
      else pass_cnt++;
      model_edge(enable, start);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    start  = 1'b0;
  endtask

  initial begin
    fill_nop();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_start();
    test_decode();
    test_stall();
    test_halt_restart();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
